// File: rtl/seg_score_display.sv
// Score/speed display stage: saturating 3-digit BCD score, 4-digit scan, blink on loss.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros of the score.
module seg_score_display #(
    parameter int unsigned REFRESH_DIV = 32'h20000,
    parameter int unsigned FLASH_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       lose,
    input  logic [1:0] speed,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

    phase_t      phase, phase_next;
    logic [31:0] blink_cnt, blink_cnt_next;
    logic [31:0] presc;
    logic [1:0]  idx;
    logic [3:0]  d2, d1, d0;
    logic [3:0]  n2, n1, n0;
    logic [3:0]  digit_val;
    logic        digit_blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Score: clear wins over tick; increments stop at 999 and while lose is high.
    always_comb begin
        n2 = d2;
        n1 = d1;
        n0 = d0;
        if (clear) begin
            n2 = '0;
            n1 = '0;
            n0 = '0;
        end else if (tick && !lose && !(d2 == 4'd9 && d1 == 4'd9 && d0 == 4'd9)) begin
            if (d0 != 4'd9) begin
                n0 = d0 + 4'd1;
            end else begin
                n0 = '0;
                if (d1 != 4'd9) begin
                    n1 = d1 + 4'd1;
                end else begin
                    n1 = '0;
                    n2 = d2 + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d2 <= '0;
            d1 <= '0;
            d0 <= '0;
        end else begin
            d2 <= n2;
            d1 <= n1;
            d0 <= n0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= REFRESH_DIV - 1;
            idx   <= '0;
        end else if (presc == '0) begin
            presc <= REFRESH_DIV - 1;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc - 32'd1;
        end
    end

    always_comb begin
        phase_next     = phase;
        blink_cnt_next = blink_cnt;
        if (!lose) begin
            phase_next     = PH_ON;
            blink_cnt_next = FLASH_DIV - 1;
        end else if (blink_cnt == '0) begin
            phase_next     = (phase == PH_ON) ? PH_OFF : PH_ON;
            blink_cnt_next = FLASH_DIV - 1;
        end else begin
            blink_cnt_next = blink_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= PH_ON;
            blink_cnt <= FLASH_DIV - 1;
        end else begin
            phase     <= phase_next;
            blink_cnt <= blink_cnt_next;
        end
    end

    always_comb begin
        digit_val   = d0;
        digit_blank = 1'b0;
        case (idx)
            2'd0: digit_val = d0;
            2'd1: begin
                digit_val = d1;
`ifdef LEAD_ZERO_BLANK_EN
                digit_blank = (d2 == 4'd0) && (d1 == 4'd0);
`else
                digit_blank = 1'b0;
`endif
            end
            2'd2: begin
                digit_val = d2;
`ifdef LEAD_ZERO_BLANK_EN
                digit_blank = (d2 == 4'd0);
`else
                digit_blank = 1'b0;
`endif
            end
            default: digit_val = (speed == 2'd3) ? 4'd3 : {2'b00, speed} + 4'd1;
        endcase
    end

    // Output gating follows phase_next so a falling lose re-enables the display on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg <= '1;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= digit_blank ? 7'b1111111 : seg7(digit_val);
            if (phase_next == PH_ON) begin
                an <= ~(4'b0001 << idx);
                dp <= (idx != 2'd3);
            end else begin
                an <= '1;
                dp <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg_score_display.md
Name: seg_score_display

Overview:
- Downstream display stage of the cliff game. Consumes the game's step tick, lose flag and speed setting, and drives the board's 4-digit seven-segment display (seg/an/dp).
- Keeps a saturating 3-digit BCD score. Shows speed level on the leftmost digit.
- Time-multiplexes the four digits and blinks the whole display after a loss.

Parameters:
- REFRESH_DIV, 32'h20000: clk cycles per digit slot (scan prescaler reload); must be >= 1.
- FLASH_DIV, 25000000: clk cycles per blink phase while lose is high; must be >= 1.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle pulse per game step; adds one point
- clear  input  1  one-cycle pulse; zeroes score (game restart)
- lose  input  1  level; freezes score, blinks display
- speed  input  2  game speed 0..2; values above 2 display as 3
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- an  output  4  anodes, active-low, an[3] = leftmost digit
- dp  output  1  decimal point, active-low

Behaviour:
- Reset: one clock, named clk; reset is asynchronous and active-low, named reset_n. While reset_n=0:
  - score digits 000, scan index 0, prescaler = REFRESH_DIV-1, blink phase on, blink counter = FLASH_DIV-1.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Reset deasserting mid-scan restarts scanning at digit 0.
- Score: three BCD registers d2,d1,d0, each 4-bit, 0..9.
  - Priority per clk edge: clear > (tick && !lose) > hold.
  - Increment is BCD with carry ripple: 009->010, 099->100.
  - Saturates at 999; further ticks hold 999.
  - clear and tick in the same cycle: result 000, tick dropped.
- Digit content:
  - slot 0 = d0, slot 1 = d1, slot 2 = d2.
  - slot 3 = speed+1 as a numeral 1..3; speed=3 shows 3.
- Scan:
  - Prescaler counts down each clk and reloads REFRESH_DIV-1 at 0.
  - On reload, scan index increments mod 4: 0->1->2->3->0.
  - an, seg and dp are registered and reflect the new index one clk after the reload.
  - Exactly one anode is low when display is on; slot n drives an[n]=0.
- dp: low only while slot 3 is active (separates speed from score); otherwise high.
- Encoding (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111
- Blink:
  - While lose=1, the blink counter counts down from FLASH_DIV-1 and toggles the blink phase at 0.
  - Phase off: an=4'b1111, dp=1. Scan and score keep their state.
  - When lose falls: blink counter reloads and phase forces on within one clk.
  - Score holds its value throughout lose=1; clear still zeroes it.
- Latency:
  - Score change is visible on seg no later than one clk after the slot for that digit next becomes active.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: leading zeros of the score are blanked (seg=1111111; anode still driven), e.g. 7 shows "  7", 40 shows " 40", 0 shows "  0". d0 is never blanked.
- Undefined: all score digits are always shown ("007").

Test Plan:
- Set REFRESH_DIV=4. Release reset -> an sequence 1110,1101,1011,0111 repeats, each held 4 clks; dp=0 only with an=0111; with speed=1 and an=0111, seg=0100100.
- Pulse tick 12 times, lose=0 -> d2..d0 = 0,1,2; slot 0 seg=0100100, slot 1 seg=1111001.
- Preload 998, tick 3 times -> 999 held; slot 0 seg=0010000.
- lose=1, FLASH_DIV=8, tick 5 times -> score unchanged; an=1111 for 8 clks, active for 8 clks, alternating; lose=0 -> scan resumes within 1 clk.
- clear and tick in the same cycle at score 57 -> score 000. Assert reset_n low mid-slot 2 -> an=1111, seg=1111111 immediately, without waiting for a clk edge.
- LEAD_ZERO_BLANK_EN defined, score 7 -> slots 2,1 seg=1111111, slot 0 seg=1111000.
